// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multi-cycle controller and the RV32I datapath/memory.
// master = controller side, slave = datapath side.
interface multicycle_control_fsm_if;
    logic [6:0] opcode;
    logic       branch_taken;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       wb_sel;
    logic       illegal_instr;
    logic       bus_error;
    logic [3:0] state_dbg;

    modport master (
        input  opcode, branch_taken, mem_ready,
        output mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_write, wb_sel,
               illegal_instr, bus_error, state_dbg
    );

    modport slave (
        output opcode, branch_taken, mem_ready,
        input  mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_write, wb_sel,
               illegal_instr, bus_error, state_dbg
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control unit: sequences fetch/decode/execute/mem/writeback
// over a shared ALU and one memory port, with illegal-opcode and memory-timeout traps.
module multicycle_control_fsm #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multicycle_control_fsm_if.master bus
);
    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        FETCH   = 4'd1,
        DECODE  = 4'd2,
        EXEC_R  = 4'd3,
        EXEC_I  = 4'd4,
        ALU_WB  = 4'd5,
        ADDR    = 4'd6,
        MEM_RD  = 4'd7,
        LOAD_WB = 4'd8,
        MEM_WR  = 4'd9,
        BRANCH  = 4'd10,
        TRAP    = 4'd11
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             illegal_q, bus_err_q;
    logic             set_illegal, set_bus_err;
    logic             mem_state, timed_out;

    assign mem_state = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);

    // cnt holds the number of earlier wait cycles, so the trap fires in the
    // TIMEOUT_CYCLES-th consecutive cycle without mem_ready.
    assign timed_out = (TIMEOUT_CYCLES != 0) && !bus.mem_ready &&
                       (int'(cnt) >= TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            illegal_q <= illegal_q | set_illegal;
            bus_err_q <= bus_err_q | set_bus_err;
        end
    end

    always_comb begin
        cnt_nxt = cnt;
        if (state_nxt != state)
            cnt_nxt = '0;
        else if (mem_state && !bus.mem_ready && (cnt != '1))
            cnt_nxt = cnt + 1'b1;
    end

    always_comb begin
        state_nxt        = state;
        set_illegal      = 1'b0;
        set_bus_err      = 1'b0;
        bus.mem_req      = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_addr_sel = 1'b0;
        bus.ir_write     = 1'b0;
        bus.pc_write     = 1'b0;
        bus.pc_src       = 1'b0;
        bus.alu_src_a    = 2'd0;
        bus.alu_src_b    = 2'd0;
        bus.alu_op       = 2'b00;
        bus.reg_write    = 1'b0;
        bus.wb_sel       = 1'b0;
        case (state)
            IDLE: state_nxt = FETCH;
            FETCH: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ready) begin
                    // PC+4 computed on the ALU while the instruction lands in IR
                    bus.ir_write  = 1'b1;
                    bus.pc_write  = 1'b1;
                    bus.alu_src_b = 2'd1;
                    state_nxt     = DECODE;
                end else if (timed_out) begin
                    set_bus_err = 1'b1;
                    state_nxt   = TRAP;
                end
            end
            DECODE: begin
                bus.alu_src_a = 2'd2;
                bus.alu_src_b = 2'd2;
                case (bus.opcode)
                    7'b0110011: state_nxt = EXEC_R;
                    7'b0010011: state_nxt = EXEC_I;
                    7'b0000011,
                    7'b0100011: state_nxt = ADDR;
                    7'b1100011: state_nxt = BRANCH;
                    default: begin
                        set_illegal = 1'b1;
                        state_nxt   = TRAP;
                    end
                endcase
            end
            EXEC_R: begin
                bus.alu_src_a = 2'd1;
                bus.alu_op    = 2'b10;
                state_nxt     = ALU_WB;
            end
            EXEC_I: begin
                bus.alu_src_a = 2'd1;
                bus.alu_src_b = 2'd2;
                bus.alu_op    = 2'b10;
                state_nxt     = ALU_WB;
            end
            ALU_WB: begin
                bus.reg_write = 1'b1;
                state_nxt     = FETCH;
            end
            ADDR: begin
                bus.alu_src_a = 2'd1;
                bus.alu_src_b = 2'd2;
                state_nxt     = (bus.opcode == 7'b0000011) ? MEM_RD : MEM_WR;
            end
            MEM_RD, MEM_WR: begin
                bus.mem_req      = 1'b1;
                bus.mem_addr_sel = 1'b1;
                bus.mem_we       = (state == MEM_WR);
                if (bus.mem_ready)
                    state_nxt = (state == MEM_RD) ? LOAD_WB : FETCH;
                else if (timed_out) begin
                    set_bus_err = 1'b1;
                    state_nxt   = TRAP;
                end
            end
            LOAD_WB: begin
                bus.reg_write = 1'b1;
                bus.wb_sel    = 1'b1;
                state_nxt     = FETCH;
            end
            BRANCH: begin
                bus.alu_src_a = 2'd1;
                bus.alu_op    = 2'b01;
                bus.pc_src    = 1'b1;
                bus.pc_write  = bus.branch_taken;
                state_nxt     = FETCH;
            end
            TRAP:    state_nxt = TRAP;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.illegal_instr = illegal_q;
    assign bus.bus_error     = bus_err_q;
    assign bus.state_dbg     = state;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class,
// memory stalls, timeout boundary, illegal trap and async reset.
module tb_multicycle_control_fsm;
    logic clk;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    multicycle_control_fsm_if bus ();

    multicycle_control_fsm #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [19:0] obs;
    assign obs = {bus.mem_req, bus.mem_we, bus.mem_addr_sel, bus.ir_write,
                  bus.pc_write, bus.pc_src, bus.alu_src_a, bus.alu_src_b,
                  bus.alu_op, bus.reg_write, bus.wb_sel, bus.illegal_instr,
                  bus.bus_error, bus.state_dbg};

    function automatic logic [19:0] o(input logic [3:0] st,
                                      input logic rq, we, as, irw, pcw, pcs,
                                      input logic [1:0] sa, sb, op,
                                      input logic rw, wb, il, be);
        return {rq, we, as, irw, pcw, pcs, sa, sb, op, rw, wb, il, be, st};
    endfunction

    logic [19:0] E_IDLE, F_WAIT, F_RDY, DEC, EXR, EXI, AWB, ADR, MRD, LWB, MWR;
    logic [19:0] BR_T, BR_N, TRAP_IL, TRAP_BE;

    task automatic chk(input string tag, input logic [19:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt(input logic rdy, input string tag, input logic [19:0] exp);
        @(negedge clk);
        bus.mem_ready = rdy;
        #1;
        chk(tag, exp);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk({tag, "_asserted"}, E_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk({tag, "_idle"}, E_IDLE);
    endtask

    initial begin
        //               st  rq we as ir pw ps sa sb op rw wb il be
        E_IDLE  = o(4'd0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        F_WAIT  = o(4'd1,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        F_RDY   = o(4'd1,  1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        DEC     = o(4'd2,  0, 0, 0, 0, 0, 0, 2, 2, 0, 0, 0, 0, 0);
        EXR     = o(4'd3,  0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0);
        EXI     = o(4'd4,  0, 0, 0, 0, 0, 0, 1, 2, 2, 0, 0, 0, 0);
        AWB     = o(4'd5,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        ADR     = o(4'd6,  0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0);
        MRD     = o(4'd7,  1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        LWB     = o(4'd8,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        MWR     = o(4'd9,  1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        BR_T    = o(4'd10, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0);
        BR_N    = o(4'd10, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
        TRAP_IL = o(4'd11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        TRAP_BE = o(4'd11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        clk = 1'b0;
        rst_n = 1'b0;
        bus.opcode = 7'b0110011;
        bus.branch_taken = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        chk("reset_state", E_IDLE);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_after_release", E_IDLE);

        // R-type, 4 cycles including fetch
        nxt(1, "r_fetch", F_RDY);
        nxt(1, "r_decode", DEC);
        nxt(1, "r_exec", EXR);
        nxt(1, "r_wb", AWB);

        bus.opcode = 7'b0010011;
        nxt(1, "i_fetch", F_RDY);
        nxt(1, "i_decode", DEC);
        nxt(1, "i_exec", EXI);
        nxt(1, "i_wb", AWB);

        // load with 3 stall cycles in MEM_RD
        bus.opcode = 7'b0000011;
        nxt(1, "ld_fetch", F_RDY);
        nxt(1, "ld_decode", DEC);
        nxt(1, "ld_addr", ADR);
        for (int i = 0; i < 3; i++) nxt(0, "ld_mem_wait", MRD);
        nxt(1, "ld_mem_ready", MRD);
        nxt(1, "ld_wb", LWB);

        bus.opcode = 7'b0100011;
        nxt(1, "st_fetch", F_RDY);
        nxt(1, "st_decode", DEC);
        nxt(1, "st_addr", ADR);
        nxt(1, "st_mem", MWR);

        bus.opcode = 7'b1100011;
        bus.branch_taken = 1'b1;
        nxt(1, "bt_fetch", F_RDY);
        nxt(1, "bt_decode", DEC);
        nxt(1, "br_taken", BR_T);
        bus.branch_taken = 1'b0;
        nxt(1, "bn_fetch", F_RDY);
        nxt(1, "bn_decode", DEC);
        nxt(1, "br_not_taken", BR_N);

        // ready arriving in the 16th fetch cycle still completes
        bus.opcode = 7'b0110011;
        for (int i = 0; i < 15; i++) nxt(0, "to16_fetch_wait", F_WAIT);
        nxt(1, "to16_fetch_ready", F_RDY);
        nxt(1, "to16_decode", DEC);
        nxt(1, "to16_exec", EXR);
        nxt(1, "to16_wb", AWB);

        // 16 cycles without ready -> bus error trap
        for (int i = 0; i < 16; i++) nxt(0, "to_fetch_wait", F_WAIT);
        nxt(0, "to_trap", TRAP_BE);
        for (int i = 0; i < 5; i++) nxt(1, "to_trap_hold", TRAP_BE);

        do_reset("rst_after_be");

        bus.opcode = 7'b1111111;
        nxt(1, "ill_fetch", F_RDY);
        nxt(1, "ill_decode", DEC);
        nxt(1, "ill_trap", TRAP_IL);
        for (int i = 0; i < 100; i++) nxt(i[0], "ill_hold", TRAP_IL);

        do_reset("rst_after_ill");

        // async reset in the middle of a stalled load
        bus.opcode = 7'b0000011;
        nxt(1, "mr_fetch", F_RDY);
        nxt(1, "mr_decode", DEC);
        nxt(1, "mr_addr", ADR);
        nxt(0, "mr_mem_wait", MRD);
        nxt(0, "mr_mem_wait", MRD);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_reset_same_cycle", E_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mr_idle", E_IDLE);
        nxt(0, "mr_refetch", F_WAIT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
